// File: rtl/phy_rx_deserializer.sv
// ---------------------------------------------------------------------------
// phy_rx_deserializer
//   Serial-to-parallel receiver with comma-based byte alignment. Bits arrive
//   MSB first on clk_32f. The receiver hunts for the comma byte at every bit
//   position (SEARCH). It then needs SYNC_COMS consecutive aligned commas
//   (SYNC) before it distributes data bytes round-robin over four lanes
//   (ACTIVE). In ACTIVE, a comma re-anchors the lane pointer to lane 0. An
//   idle byte consumes a lane slot but produces no output.
//
//   Optional feature macro: RX_ERR_CNT_EN
//     Adds the err_cnt output. It is a saturating count of commas that arrive
//     while ACTIVE with the lane pointer away from lane 0.
// ---------------------------------------------------------------------------
module phy_rx_deserializer #(
  parameter logic [7:0] COM       = 8'hBC,
  parameter logic [7:0] IDL       = 8'h7C,
  parameter int         SYNC_COMS = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out0,
  output logic [7:0] data_out1,
  output logic [7:0] data_out2,
  output logic [7:0] data_out3,
  output logic       valid_out0,
  output logic       valid_out1,
  output logic       valid_out2,
  output logic       valid_out3,
  output logic       active
`ifdef RX_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam logic [7:0] SYNC_TARGET = 8'(SYNC_COMS);

  logic [1:0] state_q,    state_d;
  logic [7:0] sr_q,       sr_d;
  logic [2:0] bit_cnt_q,  bit_cnt_d;
  logic [7:0] com_cnt_q,  com_cnt_d;
  logic [1:0] lane_ptr_q, lane_ptr_d;
  logic [7:0] data_q [4];
  logic [7:0] data_d [4];
  logic [3:0] valid_q,    valid_d;
  logic       active_q,   active_d;
`ifdef RX_ERR_CNT_EN
  logic [7:0] err_cnt_q,  err_cnt_d;
`endif

  // The candidate byte includes the bit being sampled on this edge. This lets
  // a byte be recognised on the same edge as its 8th bit.
  logic [7:0] cand;
  logic       byte_done;

  assign cand      = {sr_q[6:0], data_in};
  assign byte_done = (bit_cnt_q == 3'd7);

  // Next-state logic for alignment, sync counting and lane distribution.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves a value unassigned, which would infer a latch.
    state_d    = state_q;
    sr_d       = cand;
    bit_cnt_d  = bit_cnt_q;
    com_cnt_d  = com_cnt_q;
    lane_ptr_d = lane_ptr_q;
    data_d     = data_q;
    valid_d    = '0;
    active_d   = active_q;
`ifdef RX_ERR_CNT_EN
    err_cnt_d  = err_cnt_q;
`endif

    case (state_q)
      ST_SEARCH: begin
        bit_cnt_d = 3'd0;
        if (cand == COM) begin
          state_d   = ST_SYNC;
          com_cnt_d = 8'd1;
        end
      end

      ST_SYNC: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (byte_done) begin
          if (cand == COM) begin
            com_cnt_d = com_cnt_q + 8'd1;
            if (com_cnt_q + 8'd1 == SYNC_TARGET) begin
              state_d    = ST_ACTIVE;
              lane_ptr_d = 2'd0;
              active_d   = 1'b1;
            end
          end else begin
            // The alignment guess was wrong. Go back to hunting bit by bit.
            state_d   = ST_SEARCH;
            com_cnt_d = 8'd0;
          end
        end
      end

      ST_ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (byte_done) begin
          if (cand == COM) begin
`ifdef RX_ERR_CNT_EN
            if (lane_ptr_q != 2'd0 && err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
`endif
            lane_ptr_d = 2'd0;
          end else if (cand == IDL) begin
            lane_ptr_d = lane_ptr_q + 2'd1;
          end else begin
            data_d[lane_ptr_q]  = cand;
            valid_d[lane_ptr_q] = 1'b1;
            lane_ptr_d          = lane_ptr_q + 2'd1;
          end
        end
      end

      default: begin
        state_d = ST_SEARCH;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_32f or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= ST_SEARCH;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      com_cnt_q  <= '0;
      lane_ptr_q <= '0;
      valid_q    <= '0;
      active_q   <= 1'b0;
      // NOTE: the lane holding registers form a small array. They still get
      // a reset because their outputs must read 8'h00 right after reset.
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
`ifdef RX_ERR_CNT_EN
      err_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      com_cnt_q  <= com_cnt_d;
      lane_ptr_q <= lane_ptr_d;
      valid_q    <= valid_d;
      active_q   <= active_d;
      data_q     <= data_d;
`ifdef RX_ERR_CNT_EN
      err_cnt_q  <= err_cnt_d;
`endif
    end
  end

  assign data_out0  = data_q[0];
  assign data_out1  = data_q[1];
  assign data_out2  = data_q[2];
  assign data_out3  = data_q[3];
  assign valid_out0 = valid_q[0];
  assign valid_out1 = valid_q[1];
  assign valid_out2 = valid_q[2];
  assign valid_out3 = valid_q[3];
  assign active     = active_q;
`ifdef RX_ERR_CNT_EN
  assign err_cnt    = err_cnt_q;
`endif

endmodule

// File: doc/phy_rx_deserializer.md
PHY_RX_DESERIALIZER -- requirements
Module: phy_rx_deserializer

Interface
REQ-001 SHALL have port clk_32f, input, 1, sole clock; bit-rate clock, all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have port data_in, input, 1, serial bit stream, MSB of each byte first.
REQ-004 SHALL have ports data_out0..data_out3, output, 8 each, last byte delivered to lane 0..3.
REQ-005 SHALL have ports valid_out0..valid_out3, output, 1 each, single-cycle pulse when the matching data_outK updates.
REQ-006 SHALL have port active, output, 1, high while the receiver is in ACTIVE.
REQ-007 SHALL have port err_cnt, output, 8, misalignment counter; present only with RX_ERR_CNT_EN.
REQ-008 SHALL use parameters COM, default 8'hBC, comma byte; IDL, default 8'h7C, idle-slot byte; SYNC_COMS, default 4, consecutive commas needed to go ACTIVE.

Function
REQ-009 SHALL shift data_in into an 8-bit register sr each edge; candidate byte = {sr[6:0], data_in}.
REQ-010 SHALL implement states SEARCH, SYNC, ACTIVE; reset state SEARCH.
REQ-011 SEARCH: candidate checked every edge; on COM -> SYNC, bit_cnt cleared, com_cnt = 1.
REQ-012 SYNC/ACTIVE: 3-bit bit_cnt increments each edge, wraps 7 -> 0; a byte is complete on the edge where bit_cnt == 7.
REQ-013 SYNC: complete byte == COM increments com_cnt; when com_cnt reaches SYNC_COMS -> ACTIVE, lane_ptr = 0, active = 1, all on that edge.
REQ-014 SYNC: complete byte != COM -> SEARCH, com_cnt = 0; no lane output.
REQ-015 ACTIVE, byte == COM: lane_ptr forced to 0, no valid pulse, no data_out change.
REQ-016 ACTIVE, byte == IDL: no valid pulse, data_out unchanged, lane_ptr advances (slot consumed).
REQ-017 ACTIVE, any other byte: data_out[lane_ptr] = byte and valid_out[lane_ptr] = 1 on the completing edge; lane_ptr advances 0->1->2->3->0.
REQ-018 Latency: data_outK/valid_outK registered on the same edge that samples the byte's 8th bit; valid low on all other edges.
REQ-019 At most one valid_outK high per cycle; data_outK holds value between updates.
REQ-020 ACTIVE is left only by reset.

Reset
REQ-021 Asserting reset SHALL immediately (no clock) force: state SEARCH, sr = 0, bit_cnt = 0, com_cnt = 0, lane_ptr = 0, data_out0..3 = 8'h00, valid_out0..3 = 0, active = 0, err_cnt = 0.
REQ-022 Reset mid-byte SHALL discard the partial byte; after release, alignment restarts from SEARCH.
REQ-023 First edge after reset release SHALL sample data_in normally.

Configuration
REQ-024 Macro RX_ERR_CNT_EN defined: err_cnt port present; in ACTIVE, COM received with lane_ptr != 0 increments err_cnt, saturating at 8'hFF.
REQ-025 Macro RX_ERR_CNT_EN undefined: no err_cnt port or counter logic; all other behaviour identical.

Verification
REQ-026 Reset, then 4x 0xBC, then 0x11,0x22,0x33,0x44 -> active rises on 32nd bit edge; data_out0..3 = 11,22,33,44, each valid pulse one cycle, 8 cycles apart.
REQ-027 3 leading junk bits, 4x 0xBC, 0xA5 -> bit alignment found in SEARCH; data_out0 = A5 with valid_out0.
REQ-028 ACTIVE: 0x01, 0x7C, 0x03, 0x04 -> lane0 = 01, lane1 no pulse, lane2 = 03, lane3 = 04.
REQ-029 SYNC: 0xBC,0xBC,0x55 -> return to SEARCH, active stays 0, no valid pulses; then 4x 0xBC -> active = 1.
REQ-030 RX_ERR_CNT_EN: ACTIVE, 0x10, 0xBC, 0x20 -> err_cnt = 1, data_out0 = 20 after comma; 300 such events -> err_cnt = FF.
REQ-031 reset asserted at bit 5 of a data byte in ACTIVE -> all outputs 0 asynchronously; no valid pulse for that byte.
